// File: rtl/calc_seq.sv
// calc_seq: four-function decimal calculator core, keypad handshake in, BCD digit scan out.
// Divider is built only when CALC_SEQ_DIV_EN is defined; otherwise cmd D raises an error.
module calc_seq #(
  parameter int NDIG = 8,
  parameter int W    = 27
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [3:0] cmd,
  output logic       cmd_ready,
  output logic [1:0] status,
  output logic [3:0] data,
  output logic [3:0] pos,
  output logic       data_valid
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] MAXV = pow10(NDIG) - 64'd1;
  localparam logic [63:0] LIM  = pow10(NDIG - 1);
  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * NDIG;
  localparam int W2 = 2 * W;
`ifdef CALC_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ENT_A, ENT_B, EXEC, MUL, CONV, SCAN, ERR
`ifdef CALC_SEQ_DIV_EN
    , DIV
`endif
  } state_t;

  state_t state, state_d;
  logic [W-1:0]  acc, acc_d, rega, rega_d, regb, regb_d;
  logic [W-1:0]  sh, sh_d, base, dval, cv, fv;
  logic [3:0]    op, op_d;
  logic          fresh, fresh_d, ret_b, ret_d, boot, boot_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [BW-1:0] bcd, bcd_d, adj;
  logic [W2-1:0] prod, prod_d, mcand, mcand_d, pnx;
  logic [W:0]    sum;
  logic          acpt, go_conv, go_err, fin;
  logic          is_dig, is_op, is_eq, is_bs;
`ifdef CALC_SEQ_DIV_EN
  logic [W:0]    rtry;
  logic [W-1:0]  qnx;
`endif

  assign is_dig = cmd <= 4'd9;
  assign is_op  = (cmd >= 4'hA) && (cmd <= 4'hD);
  assign is_eq  = cmd == 4'hE;
  assign is_bs  = cmd == 4'hF;
  assign acpt   = cmd_valid & cmd_ready;

  always_comb begin
    state_d = state;
    acc_d   = acc;
    rega_d  = rega;
    regb_d  = regb;
    op_d    = op;
    fresh_d = fresh;
    ret_d   = ret_b;
    boot_d  = boot;
    cnt_d   = cnt;
    sh_d    = sh;
    bcd_d   = bcd;
    prod_d  = prod;
    mcand_d = mcand;
    adj     = bcd;
    go_conv = 1'b0;
    go_err  = 1'b0;
    fin     = 1'b0;
    cv      = acc;
    fv      = acc;
    base    = fresh ? '0 : acc;
    dval    = (64'(base) < LIM) ? base * W'(10) + W'(cmd) : base;
    sum     = {1'b0, rega} + {1'b0, regb};
    pnx     = sh[0] ? prod + mcand : prod;
`ifdef CALC_SEQ_DIV_EN
    rtry    = {prod[W-1:0], sh[W-1]};
    qnx     = {sh[W-2:0], 1'b0};
`endif
    unique case (state)
      ENT_A, ENT_B: begin
        if (boot) begin
          boot_d  = 1'b0;
          go_conv = 1'b1;
        end else if (acpt) begin
          unique case (1'b1)
            is_dig: begin
              acc_d   = dval;
              fresh_d = 1'b0;
              go_conv = 1'b1;
              cv      = dval;
            end
            is_bs: begin
              acc_d   = acc / W'(10);
              fresh_d = 1'b0;
              go_conv = 1'b1;
              cv      = acc / W'(10);
            end
            is_op: begin
              if (state == ENT_B || (!DIV_EN && cmd == 4'hD)) begin
                go_err = 1'b1;
              end else begin
                rega_d  = acc;
                op_d    = cmd;
                acc_d   = '0;
                ret_d   = 1'b1;
                fresh_d = 1'b0;
                go_conv = 1'b1;
                cv      = '0;
              end
            end
            is_eq: begin
              if (state == ENT_A) begin
                go_conv = 1'b1;
              end else begin
                regb_d = acc;
                cnt_d  = '0;
                if (op == 4'hC) begin
                  state_d = MUL;
                  prod_d  = '0;
                  mcand_d = W2'(rega);
                  sh_d    = acc;
                end
`ifdef CALC_SEQ_DIV_EN
                else if (op == 4'hD) begin
                  if (acc == '0) begin
                    go_err = 1'b1;
                  end else begin
                    state_d = DIV;
                    prod_d  = '0;
                    sh_d    = rega;
                  end
                end
`endif
                else begin
                  state_d = EXEC;
                end
              end
            end
            default: ;
          endcase
        end
      end
      EXEC: begin
        if (op == 4'hB) begin
          if (rega < regb) go_err = 1'b1;
          else begin
            fin = 1'b1;
            fv  = rega - regb;
          end
        end else if (64'(sum) > MAXV) begin
          go_err = 1'b1;
        end else begin
          fin = 1'b1;
          fv  = sum[W-1:0];
        end
      end
      MUL: begin
        prod_d  = pnx;
        mcand_d = mcand << 1;
        sh_d    = sh >> 1;
        cnt_d   = cnt + CW'(1);
        if (cnt == CW'(W - 1)) begin
          if ((pnx[W2-1:W] != '0) || (64'(pnx[W-1:0]) > MAXV)) begin
            go_err = 1'b1;
          end else begin
            fin = 1'b1;
            fv  = pnx[W-1:0];
          end
        end
      end
`ifdef CALC_SEQ_DIV_EN
      DIV: begin
        // restoring step: remainder lives in the low half of prod
        if (rtry >= {1'b0, regb}) begin
          rtry   = rtry - {1'b0, regb};
          qnx[0] = 1'b1;
        end
        prod_d = W2'(rtry[W-1:0]);
        sh_d   = qnx;
        cnt_d  = cnt + CW'(1);
        if (cnt == CW'(W - 1)) begin
          fin = 1'b1;
          fv  = qnx;
        end
      end
`endif
      CONV: begin
        for (int i = 0; i < NDIG; i++)
          if (adj[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        bcd_d = {adj[BW-2:0], sh[W-1]};
        sh_d  = sh << 1;
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(W - 1)) begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(NDIG - 1)) begin
          state_d = ret_b ? ENT_B : ENT_A;
          cnt_d   = '0;
        end
      end
      ERR: begin
        if (cnt < CW'(NDIG)) cnt_d = cnt + CW'(1);
      end
      default: state_d = ENT_A;
    endcase
    if (fin) begin
      acc_d   = fv;
      fresh_d = 1'b1;
      ret_d   = 1'b0;
      go_conv = 1'b1;
      cv      = fv;
    end
    if (go_err) begin
      state_d = ERR;
      cnt_d   = '0;
    end else if (go_conv) begin
      state_d = CONV;
      sh_d    = cv;
      bcd_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ENT_A;
      acc   <= '0;
      rega  <= '0;
      regb  <= '0;
      op    <= '0;
      fresh <= 1'b0;
      ret_b <= 1'b0;
      boot  <= 1'b1;
      cnt   <= '0;
      sh    <= '0;
      bcd   <= '0;
      prod  <= '0;
      mcand <= '0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      rega  <= rega_d;
      regb  <= regb_d;
      op    <= op_d;
      fresh <= fresh_d;
      ret_b <= ret_d;
      boot  <= boot_d;
      cnt   <= cnt_d;
      sh    <= sh_d;
      bcd   <= bcd_d;
      prod  <= prod_d;
      mcand <= mcand_d;
    end
  end

  logic idle, scan_on;
  logic [3:0] dsel;

  // ERR reuses the digit counter to scan its zeros exactly once
  always_comb begin
    idle    = ((state == ENT_A) && !boot) || (state == ENT_B);
    scan_on = (state == SCAN) || ((state == ERR) && (cnt < CW'(NDIG)));
    dsel    = 4'd0;
    for (int i = 0; i < NDIG; i++)
      if (cnt == CW'(i)) dsel = bcd[4*i +: 4];
    status     = (state == ERR) ? 2'b00 : (idle ? 2'b10 : 2'b01);
    cmd_ready  = idle;
    data_valid = scan_on;
    pos        = scan_on ? 4'(cnt) : 4'd0;
    data       = (state == SCAN) ? dsel : 4'd0;
  end

endmodule

// File: tb/tb_calc_seq.sv
// tb_calc_seq: directed keypad sequences checked against a value-level calculator model.
// Scan digits, status and accept-to-ready latency are compared every meaningful cycle.
`timescale 1ns/1ps
module tb_calc_seq;
  localparam int NDIG = 8;
  localparam int W    = 27;
  localparam longint MAXV = 99999999;
  localparam longint LIM  = 10000000;
`ifdef CALC_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic cmd_valid = 1'b0;
  logic [3:0] cmd = 4'd0;
  logic cmd_ready;
  logic [1:0] status;
  logic [3:0] data;
  logic [3:0] pos;
  logic data_valid;

  calc_seq #(.NDIG(NDIG), .W(W)) dut (
    .clock(clock),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd(cmd),
    .cmd_ready(cmd_ready),
    .status(status),
    .data(data),
    .pos(pos),
    .data_valid(data_valid)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  longint m_acc = 0;
  longint m_a = 0;
  int m_op = 0;
  bit m_fresh = 0;
  bit m_inb = 0;
  bit m_err = 0;
  longint seen_acc = 0;
  longint seen_val = -1;

  function automatic longint pw(input int i);
    longint r = 1;
    for (int k = 0; k < i; k++) r = r * 10;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  initial begin
    int e;
    forever begin
      @(negedge clock);
      if (data_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scan_extra: pos=%0d data=%0d, required no scan",
                   pos, data);
        end else begin
          e = exp_q.pop_front();
          chk("scan_pos", 64'(pos), 64'(e / 16));
          chk("scan_data", 64'(data), 64'(e % 16));
          chk("scan_status", 64'(status), m_err ? 64'd0 : 64'd1);
        end
        if (pos == 4'd0) seen_acc = 0;
        if (int'(pos) < NDIG) seen_acc += longint'(data) * pw(int'(pos));
        if (int'(pos) == NDIG - 1) seen_val = seen_acc;
      end else begin
        chk("idle_pos", 64'(pos), 64'd0);
        chk("idle_data", 64'(data), 64'd0);
      end
    end
  end

  // kind: 0 entry/rescan, 1 add/sub, 2 mul/div, 3 error
  task automatic model(input int c, output int kind);
    longint r;
    longint show;
    bit e;
    e = 0;
    kind = 0;
    show = 0;
    r = 0;
    if (c <= 9) begin
      if (m_fresh) m_acc = 0;
      if (m_acc < LIM) m_acc = m_acc * 10 + c;
      m_fresh = 0;
      show = m_acc;
    end else if (c == 15) begin
      m_acc = m_acc / 10;
      m_fresh = 0;
      show = m_acc;
    end else if (c == 14) begin
      if (!m_inb) show = m_acc;
      else begin
        case (m_op)
          10: r = m_a + m_acc;
          11: r = m_a - m_acc;
          12: r = m_a * m_acc;
          default: r = (m_acc == 0) ? -1 : m_a / m_acc;
        endcase
        e = (r < 0) || (r > MAXV);
        kind = (m_op >= 12) ? 2 : 1;
        m_acc = r;
        m_inb = 0;
        m_fresh = 1;
        show = r;
      end
    end else begin
      if (m_inb || (c == 13 && !DIV_EN)) e = 1;
      else begin
        m_a = m_acc;
        m_op = c;
        m_acc = 0;
        m_inb = 1;
        m_fresh = 0;
        show = 0;
      end
    end
    if (e) begin
      m_err = 1;
      kind = 3;
      show = 0;
    end
    for (int i = 0; i < NDIG; i++)
      exp_q.push_back(i * 16 + int'((show / pw(i)) % 10));
  endtask

  task automatic send(input int c, input int hold = 0, input bit nowait = 0);
    int kind;
    int n;
    int lat;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    if (!cmd_ready) begin
      chk("ready_before_cmd", 64'(cmd_ready), 64'd1);
      return;
    end
    model(c, kind);
    cmd = 4'(c);
    cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd = 4'd9;
    cmd_valid = (hold > 0);
    if (nowait) begin
      cmd_valid = 1'b0;
      return;
    end
    n = 1;
    if (kind == 3) begin
      while (exp_q.size() != 0 && n < 300) begin
        @(posedge clock); #1;
        n++;
      end
      chk("err_scan_drained", 64'(exp_q.size()), 64'd0);
      chk("err_status", 64'(status), 64'd0);
      chk("err_ready", 64'(cmd_ready), 64'd0);
    end else begin
      while (!cmd_ready && n < 300) begin
        @(posedge clock); #1;
        n++;
        if (n > hold) cmd_valid = 1'b0;
      end
      cmd_valid = 1'b0;
      lat = 1 + W + NDIG + ((kind == 1) ? 1 : 0) + ((kind == 2) ? W : 0);
      chk("latency", 64'(n), 64'(lat));
      chk("ready_status", 64'(status), 64'd2);
    end
  endtask

  task automatic send_str(input string s);
    byte ch;
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      if (ch >= 8'h41) send(int'(ch) - 'h41 + 10);
      else send(int'(ch) - 'h30);
    end
  endtask

  task automatic do_reset();
    int n;
    reset = 1'b0;
    cmd_valid = 1'b0;
    exp_q.delete();
    m_acc = 0;
    m_a = 0;
    m_op = 0;
    m_fresh = 0;
    m_inb = 0;
    m_err = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_status", 64'(status), 64'd1);
    chk("rst_dv", 64'(data_valid), 64'd0);
    chk("rst_pos", 64'(pos), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    for (int i = 0; i < NDIG; i++) exp_q.push_back(i * 16);
    reset = 1'b1;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    chk("boot_ready", 64'(cmd_ready), 64'd1);
    chk("boot_scan_done", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1;
    do_reset();
    chk("boot_zero", 64'(seen_val), 64'd0);
    send(1, 3);
    send_str("2A34E");
    chk("val_46", 64'(seen_val), 64'd46);

    do_reset();
    send_str("123FC7E");
    chk("val_84", 64'(seen_val), 64'd84);
    send_str("A6E");
    chk("val_90", 64'(seen_val), 64'd90);
    send_str("5");
    chk("val_fresh", 64'(seen_val), 64'd5);
    send_str("B5E");
    chk("val_sub0", 64'(seen_val), 64'd0);
    send_str("7B9E");
    cmd = 4'd1;
    cmd_valid = 1'b1;
    repeat (NDIG + 5) @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    chk("err_sticky", 64'(status), 64'd0);
    chk("err_sticky_ready", 64'(cmd_ready), 64'd0);

    do_reset();
    send_str("999999999");
    chk("val_drop", 64'(seen_val), 64'd99999999);
    send_str("A1E");

    do_reset();
    send_str("99999998A1E");
    chk("val_max", 64'(seen_val), 64'd99999999);

`ifdef CALC_SEQ_DIV_EN
    do_reset();
    send_str("100D7E");
    chk("val_div14", 64'(seen_val), 64'd14);
    do_reset();
    send_str("5D0E");
`else
    do_reset();
    send_str("5D");
`endif

    do_reset();
    send_str("5C5");
    send(14, 0, 1);
    repeat (5) @(posedge clock);
    #1;
    chk("mid_mul_busy", 64'(status), 64'd1);
    do_reset();
    chk("abort_zero", 64'(seen_val), 64'd0);
    send_str("2A3E");
    chk("val_after_abort", 64'(seen_val), 64'd5);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
